// File: rtl/burst_ram_arbiter.sv
// Round-robin arbiter that shares one burst_ram port between two clients.
// A grant covers a whole burst: the command cycle plus every write or read beat.
module burst_ram_arbiter #(
    parameter int AddressBitWidth = 10,
    parameter int BurstDataCount  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       c0_cmd,
    input  logic                       c0_cmd_en,
    input  logic [AddressBitWidth-1:0] c0_addr,
    input  logic [63:0]                c0_wr_data,
    input  logic [7:0]                 c0_data_mask,
    output logic                       c0_ack,
    output logic [63:0]                c0_rd_data,
    output logic                       c0_rd_data_valid,
    input  logic                       c1_cmd,
    input  logic                       c1_cmd_en,
    input  logic [AddressBitWidth-1:0] c1_addr,
    input  logic [63:0]                c1_wr_data,
    input  logic [7:0]                 c1_data_mask,
    output logic                       c1_ack,
    output logic [63:0]                c1_rd_data,
    output logic                       c1_rd_data_valid,
    output logic                       br_cmd,
    output logic                       br_cmd_en,
    output logic [AddressBitWidth-1:0] br_addr,
    output logic [63:0]                br_wr_data,
    output logic [7:0]                 br_data_mask,
    input  logic [63:0]                br_rd_data,
    input  logic                       br_rd_data_valid,
    input  logic                       br_busy,
    output logic                       owner
);

    localparam int CntW = $clog2(BurstDataCount) + 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            owner_nxt;
    logic [CntW-1:0] cnt;
    logic [CntW-1:0] cnt_nxt;
    logic            winner;
    logic            sel;
    logic            rd_valid_fwd;

    // On a tie the client that did not own the last burst wins.
    always_comb begin
        winner = (c0_cmd_en & c1_cmd_en) ? ~owner : c1_cmd_en;
        sel    = (state == IDLE) ? winner : owner;
    end

    always_comb begin
        br_cmd       = sel ? c1_cmd       : c0_cmd;
        br_addr      = sel ? c1_addr      : c0_addr;
        br_wr_data   = sel ? c1_wr_data   : c0_wr_data;
        br_data_mask = sel ? c1_data_mask : c0_data_mask;
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        cnt_nxt      = cnt;
        br_cmd_en    = 1'b0;
        c0_ack       = 1'b0;
        c1_ack       = 1'b0;
        rd_valid_fwd = 1'b0;
        case (state)
            IDLE: begin
                if (!br_busy && (c0_cmd_en || c1_cmd_en)) begin
                    br_cmd_en = 1'b1;
                    c0_ack    = ~winner;
                    c1_ack    = winner;
                    owner_nxt = winner;
                    cnt_nxt   = CntW'(1);
                    if (!br_cmd) begin
                        state_nxt = READ;
                    end else if (BurstDataCount > 1) begin
                        state_nxt = WRITE;
                    end
                end
            end
            WRITE: begin
                cnt_nxt = cnt + CntW'(1);
                if (cnt == CntW'(BurstDataCount - 1)) begin
                    state_nxt = IDLE;
                end
            end
            READ: begin
                // cnt runs one ahead of the beats received, since the grant loads 1.
                rd_valid_fwd = br_rd_data_valid;
                if (br_rd_data_valid) begin
                    cnt_nxt = cnt + CntW'(1);
                    if (cnt == CntW'(BurstDataCount)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign c0_rd_data       = br_rd_data;
    assign c1_rd_data       = br_rd_data;
    assign c0_rd_data_valid = rd_valid_fwd & ~owner;
    assign c1_rd_data_valid = rd_valid_fwd & owner;

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Bench for burst_ram_arbiter: behavioural burst_ram, a per-cycle reference model,
// a grant vector table, directed corner sequences and randomized two-client traffic.
module tb_burst_ram_arbiter;
    localparam int AW   = 10;
    localparam int BDC  = 4;
    localparam int MEMW = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n   = 1'b0;
    logic          br_busy = 1'b0;
    logic          c_cmd[2];
    logic          c_cmd_en[2];
    logic [AW-1:0] c_addr[2];
    logic [63:0]   c_wr_data[2];
    logic [7:0]    c_mask[2];
    logic          c_ack[2];
    logic [63:0]   c_rd_data[2];
    logic          c_rd_valid[2];
    logic          br_cmd, br_cmd_en, owner;
    logic [AW-1:0] br_addr;
    logic [63:0]   br_wr_data;
    logic [7:0]    br_data_mask;
    logic [63:0]   br_rd_data       = 64'd0;
    logic          br_rd_data_valid = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    burst_ram_arbiter #(.AddressBitWidth(AW), .BurstDataCount(BDC)) dut (
        .clk(clk), .rst_n(rst_n),
        .c0_cmd(c_cmd[0]), .c0_cmd_en(c_cmd_en[0]), .c0_addr(c_addr[0]),
        .c0_wr_data(c_wr_data[0]), .c0_data_mask(c_mask[0]), .c0_ack(c_ack[0]),
        .c0_rd_data(c_rd_data[0]), .c0_rd_data_valid(c_rd_valid[0]),
        .c1_cmd(c_cmd[1]), .c1_cmd_en(c_cmd_en[1]), .c1_addr(c_addr[1]),
        .c1_wr_data(c_wr_data[1]), .c1_data_mask(c_mask[1]), .c1_ack(c_ack[1]),
        .c1_rd_data(c_rd_data[1]), .c1_rd_data_valid(c_rd_valid[1]),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr),
        .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
        .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
        .br_busy(br_busy), .owner(owner)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural burst_ram: captures commands at negedge, streams read beats with short gaps.
    logic [63:0]   mem[MEMW];
    int            ram_wr_left = 0, ram_rd_left = 0, ram_rd_delay = 0;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr, ram_wr_idx, ram_rd_idx;
    bit            ram_gap = 1'b0;
    initial for (int i = 0; i < MEMW; i++) mem[i] = 64'd0;

    always @(negedge clk) begin
        if (ram_wr_left > 0) begin
            mem[ram_wr_addr + ram_wr_idx] = br_wr_data;
            ram_wr_idx++;
            ram_wr_left--;
        end
        if (br_cmd_en) begin
            if (br_cmd) begin
                mem[br_addr] = br_wr_data;
                ram_wr_addr  = br_addr;
                ram_wr_idx   = 1;
                ram_wr_left  = BDC - 1;
            end else begin
                ram_rd_addr  = br_addr;
                ram_rd_idx   = 0;
                ram_rd_left  = BDC;
                ram_rd_delay = $urandom_range(1, 3);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        br_rd_data_valid = 1'b0;
        if (ram_rd_left > 0) begin
            if (ram_rd_delay > 0) begin
                ram_rd_delay--;
            end else if (!ram_gap && $urandom_range(0, 2) == 0) begin
                ram_gap = 1'b1;
            end else begin
                ram_gap          = 1'b0;
                br_rd_data       = mem[ram_rd_addr + ram_rd_idx];
                br_rd_data_valid = 1'b1;
                ram_rd_idx++;
                ram_rd_left--;
            end
        end
    end

    // Reference model: bursts tracked as remaining beat counts, memory as a shadow array.
    logic [63:0]   shadow[MEMW];
    int            m_wr_left = 0, m_rd_left = 0, m_who = 0;
    logic [AW-1:0] m_addr, m_idx;
    bit            m_last = 1'b1;
    int            gq[$];
    initial for (int i = 0; i < MEMW; i++) shadow[i] = 64'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_wr_left = 0;
            m_rd_left = 0;
            m_last    = 1'b1;
        end else begin
            bit free, grant;
            int w;
            if (c_ack[0]) gq.push_back(0);
            if (c_ack[1]) gq.push_back(1);
            free  = (m_wr_left == 0) && (m_rd_left == 0);
            grant = free && !br_busy && (c_cmd_en[0] || c_cmd_en[1]);
            w     = (c_cmd_en[0] && c_cmd_en[1]) ? (m_last ? 0 : 1) : (c_cmd_en[1] ? 1 : 0);
            check("owner", owner, m_last);
            check("ack0", c_ack[0], grant && w == 0);
            check("ack1", c_ack[1], grant && w == 1);
            check("br_cmd_en", br_cmd_en, grant);
            check("valid0", c_rd_valid[0], m_rd_left > 0 && m_who == 0 && br_rd_data_valid);
            check("valid1", c_rd_valid[1], m_rd_left > 0 && m_who == 1 && br_rd_data_valid);
            if (grant) begin
                check("br_cmd", br_cmd, c_cmd[w]);
                check("br_addr", br_addr, c_addr[w]);
                m_last = (w == 1);
                m_who  = w;
                m_addr = c_addr[w];
                if (c_cmd[w]) begin
                    check("wr_beat0", br_wr_data, c_wr_data[w]);
                    check("wr_mask0", br_data_mask, c_mask[w]);
                    shadow[c_addr[w]] = c_wr_data[w];
                    m_idx     = 1;
                    m_wr_left = BDC - 1;
                end else begin
                    m_idx     = 0;
                    m_rd_left = BDC;
                end
            end else if (m_wr_left > 0) begin
                check("wr_beat", br_wr_data, c_wr_data[m_who]);
                check("wr_mask", br_data_mask, c_mask[m_who]);
                shadow[m_addr + m_idx] = c_wr_data[m_who];
                m_idx++;
                m_wr_left--;
            end else if (m_rd_left > 0 && br_rd_data_valid) begin
                check("rd_data", c_rd_data[m_who], shadow[m_addr + m_idx]);
                m_idx++;
                m_rd_left--;
            end
        end
    end

    typedef struct {
        logic          busy, en0, en1, cmd0, cmd1;
        logic [AW-1:0] a0, a1;
        logic          exp_ack0, exp_ack1, exp_en, exp_cmd;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t        vt[8];
    logic [63:0] pat[BDC] = '{64'h11, 64'h22, 64'h33, 64'h44};
    logic [63:0] beats[BDC];
    logic [63:0] rbeats[BDC];
    int          rdone = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_clients();
        for (int n = 0; n < 2; n++) begin
            c_cmd[n] = 1'b0; c_cmd_en[n] = 1'b0; c_addr[n] = '0;
            c_wr_data[n] = 64'd0; c_mask[n] = 8'd0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(input int n, output int at);
        at = -1;
        for (int t = 0; t < 400 && at < 0; t++) begin
            @(negedge clk);
            if (c_ack[n]) at = cyc;
        end
        if (at < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack%0d_timeout: got no ack, expected ack within 400 cycles", n);
        end
    endtask

    task automatic burst_write(input int n, input logic [AW-1:0] a);
        int at;
        c_cmd[n] = 1'b1; c_addr[n] = a; c_wr_data[n] = beats[0];
        c_mask[n] = 8'hFF; c_cmd_en[n] = 1'b1;
        wait_ack(n, at);
        tick();
        c_cmd_en[n] = 1'b0;
        for (int k = 1; k < BDC; k++) begin
            c_wr_data[n] = beats[k];
            if (k < BDC - 1) tick();
        end
        tick();
    endtask

    task automatic burst_read(input int n, input logic [AW-1:0] a, output int got);
        int at;
        c_cmd[n] = 1'b0; c_addr[n] = a; c_cmd_en[n] = 1'b1;
        wait_ack(n, at);
        tick();
        c_cmd_en[n] = 1'b0;
        got = 0;
        for (int t = 0; t < 60 && got < BDC; t++) begin
            @(negedge clk);
            if (c_rd_valid[n]) begin
                rbeats[got] = c_rd_data[n];
                got++;
            end
        end
        tick();
    endtask

    task automatic count_valids(input int ncyc, output int v0, output int v1);
        v0 = 0;
        v1 = 0;
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            if (c_rd_valid[0]) v0++;
            if (c_rd_valid[1]) v1++;
        end
        tick();
    endtask

    task automatic client_proc(input int n, input int nb);
        int at;
        logic wr;
        for (int b = 0; b < nb; b++) begin
            repeat ($urandom_range(0, 3)) tick();
            wr = 1'($urandom_range(0, 1));
            c_cmd[n] = wr;
            c_addr[n] = AW'($urandom_range(0, 31) + 1016);
            c_wr_data[n] = {$urandom, $urandom};
            c_mask[n] = 8'($urandom);
            c_cmd_en[n] = 1'b1;
            wait_ack(n, at);
            tick();
            c_cmd_en[n] = 1'b0;
            if (wr) begin
                for (int k = 1; k < BDC; k++) begin
                    c_wr_data[n] = {$urandom, $urandom};
                    c_mask[n] = 8'($urandom);
                    if (k < BDC - 1) tick();
                end
                tick();
            end
        end
        rdone++;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got, v0, v1, at, last_beat, ack1_at, cnt0;
        vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
        vt[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h100, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
        vt[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 10'h100, 10'h104, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
        vt[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h104, 10'h000, 1'b1, 1'b0, 1'b1, 1'b0, 10'h104};
        vt[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h000, 10'h108, 1'b0, 1'b1, 1'b1, 1'b1, 10'h108};
        vt[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'h10C, 10'h110, 1'b1, 1'b0, 1'b1, 1'b1, 10'h10C};
        vt[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'h114, 10'h118, 1'b1, 1'b0, 1'b1, 1'b0, 10'h114};
        vt[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 10'h11C, 1'b0, 1'b1, 1'b1, 1'b0, 10'h11C};
        idle_clients();
        tick();
        do_reset();

        // Grant decisions straight out of reset (owner=1, so c0 wins ties).
        for (int i = 0; i < 8; i++) begin
            idle_clients();
            br_busy = 1'b0;
            do_reset();
            br_busy = vt[i].busy;
            c_cmd_en[0] = vt[i].en0; c_cmd_en[1] = vt[i].en1;
            c_cmd[0] = vt[i].cmd0;   c_cmd[1] = vt[i].cmd1;
            c_addr[0] = vt[i].a0;    c_addr[1] = vt[i].a1;
            c_wr_data[0] = 64'hA0 + 64'(i); c_wr_data[1] = 64'hB0 + 64'(i);
            @(negedge clk);
            check("tbl_ack0", c_ack[0], vt[i].exp_ack0);
            check("tbl_ack1", c_ack[1], vt[i].exp_ack1);
            check("tbl_cmd_en", br_cmd_en, vt[i].exp_en);
            if (vt[i].exp_en) begin
                check("tbl_cmd", br_cmd, vt[i].exp_cmd);
                check("tbl_addr", br_addr, vt[i].exp_addr);
            end
            tick();
            c_cmd_en[0] = 1'b0; c_cmd_en[1] = 1'b0; br_busy = 1'b0;
            repeat (16) tick();
        end

        // Read held off while burst_ram calibrates, then issued the cycle busy falls.
        idle_clients();
        br_busy = 1'b1;
        do_reset();
        c_cmd[0] = 1'b0; c_addr[0] = 10'h010; c_cmd_en[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("busy_cmd_en", br_cmd_en, 1'b0);
            check("busy_ack0", c_ack[0], 1'b0);
            tick();
        end
        br_busy = 1'b0;
        @(negedge clk);
        check("t1_cmd_en", br_cmd_en, 1'b1);
        check("t1_cmd", br_cmd, 1'b0);
        check("t1_addr", br_addr, 10'h010);
        check("t1_ack0", c_ack[0], 1'b1);
        tick();
        c_cmd_en[0] = 1'b0;
        count_valids(30, v0, v1);
        check("t1_c0_beats", 64'(v0), 64'(BDC));
        check("t1_c1_beats", 64'(v1), 64'd0);

        // c1 write of four beats, then read back through c0.
        for (int k = 0; k < BDC; k++) beats[k] = pat[k];
        c_cmd[1] = 1'b1; c_addr[1] = 10'h020; c_wr_data[1] = pat[0]; c_mask[1] = 8'h0F;
        c_cmd_en[1] = 1'b1;
        @(negedge clk);
        check("t2_ack1", c_ack[1], 1'b1);
        check("t2_cmd_en", br_cmd_en, 1'b1);
        check("t2_cmd", br_cmd, 1'b1);
        check("t2_addr", br_addr, 10'h020);
        check("t2_beat0", br_wr_data, pat[0]);
        for (int k = 1; k < BDC; k++) begin
            tick();
            c_cmd_en[1] = 1'b0;
            c_wr_data[1] = pat[k];
            @(negedge clk);
            check("t2_beat", br_wr_data, pat[k]);
            check("t2_no_cmd_en", br_cmd_en, 1'b0);
        end
        tick();
        burst_read(0, 10'h020, got);
        check("t2_rd_count", 64'(got), 64'(BDC));
        for (int k = 0; k < BDC; k++) check("t2_rd_data", rbeats[k], pat[k]);

        // Simultaneous reads: c0 first, c1 acked right after c0's last beat.
        idle_clients();
        do_reset();
        c_addr[0] = 10'h010; c_addr[1] = 10'h020;
        c_cmd_en[0] = 1'b1; c_cmd_en[1] = 1'b1;
        @(negedge clk);
        check("t3_ack0", c_ack[0], 1'b1);
        check("t3_ack1", c_ack[1], 1'b0);
        tick();
        c_cmd_en[0] = 1'b0;
        cnt0 = 0; last_beat = -100; ack1_at = -1;
        for (int t = 0; t < 40 && ack1_at < 0; t++) begin
            @(negedge clk);
            if (t == 0) check("t3_owner0", owner, 1'b0);
            if (c_ack[1]) ack1_at = cyc;
            if (c_rd_valid[0]) begin
                cnt0++;
                if (cnt0 == BDC) last_beat = cyc;
            end
        end
        check("t3_c0_beats", 64'(cnt0), 64'(BDC));
        check("t3_ack1_cycle", 64'(ack1_at), 64'(last_beat + 1));
        tick();
        c_cmd_en[1] = 1'b0;
        @(negedge clk);
        check("t3_owner1", owner, 1'b1);
        count_valids(20, v0, v1);
        check("t3_c1_beats", 64'(v1), 64'(BDC));
        check("t3_c0_extra", 64'(v0), 64'd0);

        // c0 requests continuously; a single c1 request mid-burst takes the next grant.
        idle_clients();
        do_reset();
        gq.delete();
        c_addr[0] = 10'h030; c_cmd_en[0] = 1'b1;
        wait_ack(0, at);
        repeat (3) tick();
        c_addr[1] = 10'h040; c_cmd_en[1] = 1'b1;
        wait_ack(1, at);
        tick();
        c_cmd_en[1] = 1'b0;
        wait_ack(0, at);
        tick();
        c_cmd_en[0] = 1'b0;
        repeat (20) tick();
        check("t4_grants", 64'(gq.size()), 64'd3);
        if (gq.size() == 3) begin
            check("t4_grant0", 64'(gq[0]), 64'd0);
            check("t4_grant1", 64'(gq[1]), 64'd1);
            check("t4_grant2", 64'(gq[2]), 64'd0);
        end

        // Reset in the middle of a c1 read: leftover beats are dropped.
        idle_clients();
        c_addr[1] = 10'h020; c_cmd_en[1] = 1'b1;
        wait_ack(1, at);
        tick();
        c_cmd_en[1] = 1'b0;
        v1 = 0;
        for (int t = 0; t < 40 && v1 < 2; t++) begin
            @(negedge clk);
            if (c_rd_valid[1]) v1++;
        end
        check("t5_two_beats", 64'(v1), 64'd2);
        tick();
        do_reset();
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            check("t5_valid0", c_rd_valid[0], 1'b0);
            check("t5_valid1", c_rd_valid[1], 1'b0);
            check("t5_ack1", c_ack[1], 1'b0);
            tick();
        end
        burst_read(0, 10'h020, got);
        check("t5_rd_count", 64'(got), 64'(BDC));
        for (int k = 0; k < BDC; k++) check("t5_rd_data", rbeats[k], pat[k]);

        // Whole-memory sweep through c1.
        for (int i = 0; i < MEMW / BDC; i++) begin
            for (int k = 0; k < BDC; k++) beats[k] = {32'(i), 32'(k)};
            burst_write(1, AW'(BDC * i));
        end
        for (int i = 0; i < MEMW / BDC; i++) begin
            burst_read(1, AW'(BDC * i), got);
            check("sweep_count", 64'(got), 64'(BDC));
            for (int k = 0; k < BDC; k++) check("sweep_data", rbeats[k], {32'(i), 32'(k)});
        end

        // Random contention between both clients, including wrapping addresses.
        idle_clients();
        fork
            client_proc(0, 40);
            client_proc(1, 40);
            begin
                while (rdone < 2) begin
                    br_busy = ($urandom_range(0, 7) == 0);
                    tick();
                end
                br_busy = 1'b0;
            end
        join
        repeat (30) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
